// File: rtl/mips_hazard_forward_unit_if.sv
// ID-stage request and hazard/forwarding response bundle shared by the
// decode stage (master) and the hazard/forward unit (slave).
interface mips_hazard_forward_unit_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_DEPTH  = 2
);
  localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

  logic                            id_valid;
  logic                            id_reg_write;
  logic                            id_is_load;
  logic [REG_ADDR_W-1:0]           id_dst;
  logic [NUM_PORTS*REG_ADDR_W-1:0] id_src;
  logic [NUM_PORTS-1:0]            id_src_used;
  logic                            flush;
  logic                            freeze;
  logic                            stall;
  logic [NUM_PORTS*SEL_W-1:0]      fwd_sel;
  logic [31:0]                     stall_count;

  modport master (
    output id_valid, id_reg_write, id_is_load, id_dst, id_src, id_src_used,
    output flush, freeze,
    input  stall, fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_reg_write, id_is_load, id_dst, id_src, id_src_used,
    input  flush, freeze,
    output stall, fwd_sel, stall_count
  );
endinterface

// File: rtl/mips_hazard_forward_unit.sv
// Tracks in-flight register writes over FWD_DEPTH post-EX stages, produces
// registered EX operand forwarding selects and a load-use stall for ID/IF.
// LOAD_LATENCY + 1 must not exceed FWD_DEPTH.
module mips_hazard_forward_unit #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  mips_hazard_forward_unit_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

  logic [FWD_DEPTH-1:0]       r_valid;
  logic [FWD_DEPTH-1:0]       r_reg_write;
  logic [FWD_DEPTH-1:0]       r_is_load;
  logic [REG_ADDR_W-1:0]      r_dst [FWD_DEPTH];
  logic [NUM_PORTS*SEL_W-1:0] r_fwd_sel;
  logic [31:0]                r_stall_count;

  logic [NUM_PORTS*SEL_W-1:0] w_sel;
  logic [NUM_PORTS-1:0]       w_found;
  logic [NUM_PORTS-1:0]       w_hazard;
  logic                       w_stall;
  logic                       w_bubble;

  // Youngest matching producer wins; a load too young to forward is a hazard.
  always_comb begin
    w_sel    = '0;
    w_found  = '0;
    w_hazard = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      for (int j = 0; j < int'(FWD_DEPTH); j++) begin
        if (!w_found[p] && bus.id_src_used[p] &&
            (bus.id_src[p*REG_ADDR_W +: REG_ADDR_W] != '0) &&
            r_valid[j] && r_reg_write[j] &&
            (r_dst[j] == bus.id_src[p*REG_ADDR_W +: REG_ADDR_W])) begin
          w_found[p]                = 1'b1;
          w_sel[p*SEL_W +: SEL_W]   = SEL_W'(j + 1);
          w_hazard[p]               = r_is_load[j] && (j < int'(LOAD_LATENCY));
        end
      end
    end
  end

  assign w_stall  = bus.id_valid && !bus.flush && (|w_hazard);
  assign w_bubble = w_stall || bus.flush || !bus.id_valid;

  // Slot pipeline, registered selects and saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= '0;
      r_reg_write   <= '0;
      r_is_load     <= '0;
      for (int j = 0; j < int'(FWD_DEPTH); j++) r_dst[j] <= '0;
      r_fwd_sel     <= '0;
      r_stall_count <= '0;
    end else if (!bus.freeze) begin
      for (int j = 1; j < int'(FWD_DEPTH); j++) begin
        r_valid[j]     <= r_valid[j-1];
        r_reg_write[j] <= r_reg_write[j-1];
        r_is_load[j]   <= r_is_load[j-1];
        r_dst[j]       <= r_dst[j-1];
      end
      r_valid[0]     <= !w_bubble;
      r_reg_write[0] <= !w_bubble && bus.id_reg_write;
      r_is_load[0]   <= !w_bubble && bus.id_is_load;
      r_dst[0]       <= w_bubble ? '0 : bus.id_dst;
      r_fwd_sel      <= w_bubble ? '0 : w_sel;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.fwd_sel     = r_fwd_sel;
  assign bus.stall_count = r_stall_count;

endmodule
